// File: rtl/alu_seq_n_if.sv
// Operand/result bundle for alu_seq_n: the operand handshake from the decode stage
// and the registered result with its flags towards writeback.
interface alu_seq_n_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [2:0]   opc;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic         neg;
    logic         carry;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, opc,
        input  in_ready, out_valid, result, zero, neg, carry, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, opc,
        output in_ready, out_valid, result, zero, neg, carry, ovf
    );
endinterface

// File: rtl/alu_seq_n.sv
// Registered W-bit ALU with valid/ready operand capture, carry/overflow flags and a
// W-cycle shift-add multiplier that stalls the input while it runs.
module alu_seq_n #(
    parameter int W = 16
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_n_if.slave bus
);
    localparam int SW = $clog2(W);
    localparam logic [SW-1:0] CNT_LAST = SW'(W - 1);
    localparam logic [SW-1:0] CNT_ONE  = SW'(1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SAR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MULT = 1'b1
    } state_t;

    // Signed overflow of x + y given the sign bits of both addends and of the sum.
    function automatic logic add_ovf(input logic x_msb, input logic y_msb, input logic r_msb);
        return (x_msb == y_msb) && (r_msb != x_msb);
    endfunction

    state_t         state_q, state_d;
    logic           op_vld_q, op_vld_d;
    logic [W-1:0]   op_a_q, op_a_d;
    logic [W-1:0]   op_b_q, op_b_d;
    logic           op_cin_q, op_cin_d;
    logic [2:0]     op_opc_q, op_opc_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [SW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   result_q, result_d;
    logic           zero_q, zero_d;
    logic           neg_q, neg_d;
    logic           carry_q, carry_d;
    logic           ovf_q, ovf_d;
    logic           out_valid_q, out_valid_d;

    logic           accept_s;
    logic           mul_done_s;
    logic [W-1:0]   acc_step_s;
    logic [SW-1:0]  sh_s;
    logic [W:0]     add_s;
    logic [W:0]     sub_s;
    logic [W:0]     shl_s;
    logic signed [W:0] sar_in_s;
    logic signed [W:0] sar_s;
    logic [W-1:0]   alu_res_s;
    logic           alu_carry_s;
    logic           alu_ovf_s;

    assign accept_s = bus.in_valid && (state_q == ST_IDLE);

    // Operand capture stage for the single-cycle opcodes.
    always_comb begin
        op_vld_d = 1'b0;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        op_cin_d = op_cin_q;
        op_opc_d = op_opc_q;
        if (accept_s && (bus.opc != OP_MUL)) begin
            op_vld_d = 1'b1;
            op_a_d   = bus.a;
            op_b_d   = bus.b;
            op_cin_d = bus.cin;
            op_opc_d = bus.opc;
        end else begin
            op_vld_d = 1'b0;
        end
    end

    // Single-cycle datapath on the captured operands; the shifts carry one guard bit
    // so the last bit shifted out falls into bit W (SHL) or bit 0 (SAR).
    always_comb begin
        sh_s        = op_b_q[SW-1:0];
        add_s       = {1'b0, op_a_q} + {1'b0, op_b_q} + {{W{1'b0}}, op_cin_q};
        sub_s       = {1'b0, op_a_q} + {1'b0, ~op_b_q} + {{W{1'b0}}, 1'b1};
        shl_s       = {1'b0, op_a_q} << sh_s;
        sar_in_s    = {op_a_q, 1'b0};
        sar_s       = sar_in_s >>> sh_s;
        alu_res_s   = {W{1'b0}};
        alu_carry_s = 1'b0;
        alu_ovf_s   = 1'b0;
        case (op_opc_q)
            OP_ADD: begin
                alu_res_s   = add_s[W-1:0];
                alu_carry_s = add_s[W];
                alu_ovf_s   = add_ovf(op_a_q[W-1], op_b_q[W-1], add_s[W-1]);
            end
            OP_SUB: begin
                alu_res_s   = sub_s[W-1:0];
                alu_carry_s = sub_s[W];
                alu_ovf_s   = add_ovf(op_a_q[W-1], ~op_b_q[W-1], sub_s[W-1]);
            end
            OP_AND: alu_res_s = op_a_q & op_b_q;
            OP_OR:  alu_res_s = op_a_q | op_b_q;
            OP_XOR: alu_res_s = op_a_q ^ op_b_q;
            OP_SHL: begin
                alu_res_s   = shl_s[W-1:0];
                alu_carry_s = shl_s[W];
            end
            OP_SAR: begin
                alu_res_s   = sar_s[W:1];
                alu_carry_s = sar_s[0];
            end
            default: begin
                alu_res_s   = {W{1'b0}};
                alu_carry_s = 1'b0;
                alu_ovf_s   = 1'b0;
            end
        endcase
    end

    // Multiply sequencer: one shift-add step per cycle for W cycles.
    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        mul_done_s = 1'b0;
        acc_step_s = acc_q + (mplier_q[0] ? mcand_q : {W{1'b0}});
        case (state_q)
            ST_IDLE: begin
                if (accept_s && (bus.opc == OP_MUL)) begin
                    mcand_d  = bus.a;
                    mplier_d = bus.b;
                    acc_d    = {W{1'b0}};
                    cnt_d    = {SW{1'b0}};
                    state_d  = ST_MULT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_MULT: begin
                acc_d    = acc_step_s;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    mul_done_s = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d    = ST_MULT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Result/flag register update; a multiply and a single-cycle op never finish together.
    always_comb begin
        out_valid_d = 1'b0;
        result_d    = result_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        if (mul_done_s) begin
            out_valid_d = 1'b1;
            result_d    = acc_step_s;
            carry_d     = 1'b0;
            ovf_d       = 1'b0;
        end else if (op_vld_q) begin
            out_valid_d = 1'b1;
            result_d    = alu_res_s;
            carry_d     = alu_carry_s;
            ovf_d       = alu_ovf_s;
        end else begin
            out_valid_d = 1'b0;
        end
        zero_d = (result_d == {W{1'b0}});
        neg_d  = result_d[W-1];
        if (!(mul_done_s || op_vld_q)) begin
            zero_d = zero_q;
            neg_d  = neg_q;
        end else begin
            neg_d  = result_d[W-1];
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_vld_q    <= 1'b0;
            op_a_q      <= {W{1'b0}};
            op_b_q      <= {W{1'b0}};
            op_cin_q    <= 1'b0;
            op_opc_q    <= 3'd0;
            mcand_q     <= {W{1'b0}};
            mplier_q    <= {W{1'b0}};
            acc_q       <= {W{1'b0}};
            cnt_q       <= {SW{1'b0}};
            result_q    <= {W{1'b0}};
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_vld_q    <= op_vld_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_cin_q    <= op_cin_d;
            op_opc_q    <= op_opc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.carry     = carry_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_alu_seq_n.sv
// Self-checking bench for alu_seq_n (W=16): directed corner cases plus random
// traffic compared against an arithmetic reference model.
module tb_alu_seq_n;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_seq_n_if #(.W(W)) bus();
    alu_seq_n #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_bad = 0;

    // {out_valid, result, zero, neg, carry, ovf}
    typedef logic [W+4:0] obs_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] res;
        logic        c;
        logic        v;
    } dvec_t;

    function automatic obs_t observe();
        return {bus.out_valid, bus.result, bus.zero, bus.neg, bus.carry, bus.ovf};
    endfunction

    // Reference: {ovf, carry, result} from plain integer arithmetic.
    function automatic logic [17:0] ref_op(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic cin);
        longint ua = a;
        longint ub = b;
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint ci = cin;
        longint sh = b[3:0];
        longint r  = 0;
        longint s  = 0;
        logic   c  = 1'b0;
        logic   v  = 1'b0;
        case (op)
            3'd0: begin r = ua + ub + ci; c = (r > 65535); s = sa + sb + ci; v = (s > 32767) || (s < -32768); end
            3'd1: begin r = ua - ub; c = (ua >= ub); s = sa - sb; v = (s > 32767) || (s < -32768); end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: begin r = ua << sh; c = (sh != 0) && (((ua >> (16 - sh)) & 1) != 0); end
            3'd6: begin r = sa >>> sh; c = (sh != 0) && (((ua >> (sh - 1)) & 1) != 0); end
            default: r = ua * ub;
        endcase
        return {v, c, r[15:0]};
    endfunction

    function automatic obs_t done_of(input logic [17:0] m);
        return {1'b1, m[15:0], (m[15:0] == 16'h0000), m[15], m[16], m[17]};
    endfunction

    function automatic logic [15:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'h7FFF;
            2: return 16'h8000;
            3: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic cin);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opc = op;
        bus.a = a;
        bus.b = b;
        bus.cin = cin;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [W+5:0] got;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        got = {bus.in_ready, observe()};
        n_vec++;
        if (got !== {1'b1, {(W+5){1'b0}}}) begin
            n_bad++;
            $display("FAIL reset_state: got %h expected %h", got, {1'b1, {(W+5){1'b0}}});
        end
        rst = 1'b0;
    endtask

    task automatic test_arith();
        dvec_t tbl [5];
        obs_t exp, got;
        tbl[0] = '{3'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[1] = '{3'd0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{3'd1, 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[3] = '{3'd1, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{3'd1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin);
            @(negedge clk);
            exp = {1'b1, tbl[i].res, (tbl[i].res == 16'h0000), tbl[i].res[15], tbl[i].c, tbl[i].v};
            got = observe();
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL arith[%0d]: got %h expected %h", i, got, exp);
            end
            @(negedge clk);
            exp[W+4] = 1'b0;
            got = observe();
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL arith_hold[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_shift();
        dvec_t tbl [4];
        obs_t exp, got;
        tbl[0] = '{3'd5, 16'h8001, 16'h0001, 1'b0, 16'h0002, 1'b1, 1'b0};
        tbl[1] = '{3'd6, 16'h8000, 16'h0003, 1'b0, 16'hF000, 1'b0, 1'b0};
        tbl[2] = '{3'd6, 16'h0005, 16'hFFF0, 1'b1, 16'h0005, 1'b0, 1'b0};
        tbl[3] = '{3'd5, 16'h0003, 16'h000F, 1'b0, 16'h8000, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin);
            @(negedge clk);
            exp = {1'b1, tbl[i].res, (tbl[i].res == 16'h0000), tbl[i].res[15], tbl[i].c, tbl[i].v};
            got = observe();
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL shift[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_mul();
        int busy_cycles = 0;
        int early = 0;
        int lat;
        logic [15:0] ma, mb;
        logic [W+5:0] got6;
        obs_t got, exp;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.opc = 3'd7; bus.a = 16'hFFFD; bus.b = 16'h0007; bus.cin = 1'b0;
        @(negedge clk);
        bus.opc = 3'd0; bus.a = 16'h0001; bus.b = 16'h0001;
        for (int j = 0; j < 16; j++) begin
            if (!bus.in_ready) busy_cycles++;
            if (bus.out_valid) early++;
            if (j == 15) bus.in_valid = 1'b0;
            @(negedge clk);
        end
        n_vec++;
        if (busy_cycles !== 16 || early !== 0) begin
            n_bad++;
            $display("FAIL mul_busy: got busy=%0d early=%0d expected busy=16 early=0", busy_cycles, early);
        end
        got6 = {bus.in_ready, observe()};
        n_vec++;
        if (got6 !== {1'b1, 1'b1, 16'hFFEB, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL mul_result: got %h expected %h", got6, {1'b1, 1'b1, 16'hFFEB, 4'b0100});
        end
        @(negedge clk);
        got = observe();
        n_vec++;
        if (got !== {1'b0, 16'hFFEB, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL mul_no_extra: got %h expected %h", got, {1'b0, 16'hFFEB, 4'b0100});
        end
        for (int i = 0; i < 4; i++) begin
            ma = (i == 0) ? 16'h0100 : pick_val();
            mb = (i == 0) ? 16'h0100 : 16'($urandom);
            send(3'd7, ma, mb, 1'b0);
            lat = 0;
            while (!bus.out_valid && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            exp = done_of(ref_op(3'd7, ma, mb, 1'b0));
            got = observe();
            n_vec++;
            if (lat !== 16 || got !== exp) begin
                n_bad++;
                $display("FAIL mul[%0d]: got lat=%0d %h expected lat=16 %h", i, lat, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        int stray = 0;
        logic [W+5:0] got6;
        obs_t got, exp;
        send(3'd0, 16'h0001, 16'h0001, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.opc = 3'd7; bus.a = 16'h1234; bus.b = 16'h5678;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        got6 = {bus.in_ready, observe()};
        n_vec++;
        if (got6 !== {1'b1, {(W+5){1'b0}}}) begin
            n_bad++;
            $display("FAIL mid_mul_reset: got %h expected %h", got6, {1'b1, {(W+5){1'b0}}});
        end
        for (int j = 0; j < 24; j++) begin
            @(negedge clk);
            if (bus.out_valid) stray++;
        end
        n_vec++;
        if (stray !== 0) begin
            n_bad++;
            $display("FAIL aborted_mul_valid: got %0d pulses expected 0", stray);
        end
        send(3'd0, 16'h0010, 16'h0020, 1'b1);
        @(negedge clk);
        exp = done_of(ref_op(3'd0, 16'h0010, 16'h0020, 1'b1));
        got = observe();
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL add_after_reset: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_back_to_back();
        obs_t hold, exp;
        logic [W+5:0] got6;
        logic s1_v, s2_v;
        logic [17:0] s1_m, s2_m;
        logic [2:0] op;
        logic [15:0] a, b;
        logic cin;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hold = {(W+5){1'b0}};
        s1_v = 1'b0; s2_v = 1'b0; s1_m = 18'h0; s2_m = 18'h0;
        for (int cyc = 0; cyc < 202; cyc++) begin
            if (s2_v) begin
                exp = done_of(s2_m);
                hold = {1'b0, exp[W+3:0]};
            end else begin
                exp = hold;
            end
            got6 = {bus.in_ready, observe()};
            n_vec++;
            if (got6 !== {1'b1, exp}) begin
                n_bad++;
                $display("FAIL b2b[%0d]: got %h expected %h", cyc, got6, {1'b1, exp});
            end
            s2_v = s1_v;
            s2_m = s1_m;
            if (cyc < 200) begin
                op = 3'($urandom_range(0, 6));
                a = pick_val();
                b = pick_val();
                cin = 1'($urandom);
                s1_v = ($urandom_range(0, 7) != 0);
                s1_m = ref_op(op, a, b, cin);
                bus.in_valid = s1_v; bus.opc = op; bus.a = a; bus.b = b; bus.cin = cin;
            end else begin
                s1_v = 1'b0;
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.a = 16'h0000;
        bus.b = 16'h0000;
        bus.cin = 1'b0;
        bus.opc = 3'd0;
        test_reset();
        test_arith();
        test_shift();
        test_mul();
        test_reset_mid_mul();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
